seq_compare_unit: RTL
=====================

# seq_compare_unit

Parametrised, multi-cycle compare unit for the execute stage, successor to the single-cycle set-less-than comparator. It evaluates signed/unsigned less-than, equality, and min/max selection on XLEN-bit operands. It scans CHUNK bits per cycle, MSB first, and terminates early at the first differing chunk. Operands enter and results leave through valid/ready handshakes, so the unit can sit between operand fetch and writeback without a fixed latency.

## Interface
Parameters:
- XLEN, 32, operand/result width; XLEN % CHUNK must be 0, otherwise elaboration fails
- CHUNK, 8, bits compared per cycle; CHUNK == XLEN gives single-cycle evaluation

Ports:
- clk  input  1  clock; one clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand/op presented
- in_ready  output  1  unit can accept; = (state==IDLE) & ~flush
- op  input  3  compare operation, cmp_op encoding below
- op1  input  XLEN  rs1
- op2  input  XLEN  rs2 or immediate, selected outside
- flush  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result

## Operation
- op encoding:
  - 000 SLT: signed a<b → 1, else 0
  - 001 SLTU: unsigned a<b → 1, else 0
  - 010 MIN: signed minimum of op1, op2
  - 011 MINU: unsigned minimum
  - 100 MAX: signed maximum
  - 101 MAXU: unsigned maximum
  - 110 SEQ: a==b → 1, else 0
  - 111 reserved → result 0, full-scan latency
- Acceptance: in_valid & in_ready captures op, op1, op2 into internal registers and sets chunk index to N-1 (MSB chunk), where N = XLEN/CHUNK.
- Signed ops: the operand MSBs are inverted before comparison (offset binary), so the scan itself is always unsigned.
- States:
  - IDLE: waits for acceptance → BUSY.
  - BUSY: each cycle compares chunk[idx] of a and b.
    - Chunks differ: lt = a_chunk < b_chunk, decided → DONE.
    - Chunks equal and idx==0: eq=1, lt=0 → DONE.
    - Otherwise idx decrements and the unit stays in BUSY.
  - DONE: out_valid=1, result held stable; out_valid & out_ready → IDLE.
- Result formation at decision:
  - SLT/SLTU: {XLEN-1 zeros, lt}
  - MIN/MINU: lt ? op1 : op2
  - MAX/MAXU: lt ? op2 : op1 (equal operands return op1)
  - SEQ: {zeros, eq}
- Results are computed from the original, un-inverted operands.
- flush=1 in any state → IDLE next edge, out_valid=0 next edge; in-flight result discarded. No acceptance while flush=1.
- No back-to-back overlap: after a DONE handshake, in_ready is asserted the following cycle.

## Timing
- Reset (rst_n low at an edge): state IDLE, out_valid 0, result 0, idx 0. in_ready is 1 once rst_n is high and flush is 0.
- Latency: out_valid rises k edges after the acceptance edge. k = 1 + number of equal MSB-side chunks before the first difference, with 1 ≤ k ≤ N. Equal operands and reserved op take k=N.
- CHUNK==XLEN: k=1 always.
- result and out_valid are registers. Both stay stable while out_valid & ~out_ready.
- rst_n low overrides flush and every handshake. Reset mid-BUSY or mid-DONE drops the operation silently.
- flush and out_ready asserted in the same cycle in DONE: flush wins (same end state, IDLE, with no second result).

## Structure
- Package cmp_pkg:
  - cmp_op_e enum (the codes above)
  - state enum {IDLE, BUSY, DONE}
  - localparams OPCODE_R=7'b0110011 and OPCODE_I=7'b0010011, for the decoder mapping func3 010→SLT and 011→SLTU
- Sub-module cmp_chunk_slice: combinational CHUNK-bit compare producing lt and eq, instantiated once and muxed by idx.
- Top holds the FSM, operand registers, idx counter, and result mux; target 150-250 lines.

## Test plan
- XLEN=32, CHUNK=8, SLT op1=0xFFFFFFFF (-1), op2=0x00000001 → result 1, out_valid 1 edge after accept.
- SLTU, same operands → result 0, latency 1.
- MAXU op1=0x12345678, op2=0x12345679 → result 0x12345679, latency 4; SEQ with equal operands → 1, latency 4.
- Hold out_ready=0 for 5 cycles in DONE → result and out_valid stable and in_ready=0; then out_ready=1 → IDLE, in_ready=1 next cycle.
- flush asserted on the 2nd BUSY cycle of an equal-operand SEQ → out_valid never rises, in_ready=1 the following cycle; rst_n low mid-BUSY → out_valid=0, result=0.
- CHUNK=32: MIN op1=0x80000000, op2=0x7FFFFFFF → result 0x80000000, latency 1; op=111 → result 0.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the sequential compare unit
package cmp_pkg;

  typedef enum logic [2:0] {
    CMP_SLT  = 3'b000,
    CMP_SLTU = 3'b001,
    CMP_MIN  = 3'b010,
    CMP_MINU = 3'b011,
    CMP_MAX  = 3'b100,
    CMP_MAXU = 3'b101,
    CMP_SEQ  = 3'b110,
    CMP_RSVD = 3'b111
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Decoder maps func3 010 -> SLT and 011 -> SLTU under these opcodes.
  localparam logic [6:0] OPCODE_R   = 7'b0110011;
  localparam logic [6:0] OPCODE_I   = 7'b0010011;
  localparam logic [2:0] FUNC3_SLT  = 3'b010;
  localparam logic [2:0] FUNC3_SLTU = 3'b011;

  function automatic logic is_signed_op(cmp_op_e op);
    return (op == CMP_SLT) || (op == CMP_MIN) || (op == CMP_MAX);
  endfunction

endpackage

// File: rtl/cmp_chunk_slice.sv
// rtl/cmp_chunk_slice.sv - combinational unsigned compare of one operand chunk
module cmp_chunk_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o,
  output logic         eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/seq_compare_unit.sv
// rtl/seq_compare_unit.sv - multi-cycle MSB-first compare with early exit and valid/ready handshakes
module seq_compare_unit
  import cmp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int N    = XLEN / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  generate
    if (XLEN % CHUNK != 0) begin : g_bad_chunk
      $error("seq_compare_unit: XLEN must be a multiple of CHUNK");
    end
  endgenerate

  state_e            state_q, state_d;
  cmp_op_e           op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              out_valid_q, out_valid_d;

  logic [XLEN-1:0]   flip, a_key, b_key;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic              s_lt, s_eq;

  // Signed ops compare in offset binary; reserved op forces equal keys so it scans all chunks.
  always_comb begin
    flip            = '0;
    flip[XLEN-1]    = is_signed_op(op_q);
    a_key           = (op_q == CMP_RSVD) ? '0 : (a_q ^ flip);
    b_key           = (op_q == CMP_RSVD) ? '0 : (b_q ^ flip);
  end

  assign a_chunk = a_key[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk = b_key[int'(idx_q)*CHUNK +: CHUNK];

  cmp_chunk_slice #(.W(CHUNK)) u_slice (
    .a_i  (a_chunk),
    .b_i  (b_chunk),
    .lt_o (s_lt),
    .eq_o (s_eq)
  );

  function automatic logic [XLEN-1:0] form_result(cmp_op_e o, logic lt, logic eq,
                                                  logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (o)
      CMP_SLT, CMP_SLTU: r[0] = lt;
      CMP_MIN, CMP_MINU: r    = lt ? a : b;
      CMP_MAX, CMP_MAXU: r    = lt ? b : a;
      CMP_SEQ:           r[0] = eq;
      default:           r    = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) & ~flush;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = cmp_op_e'(op);
          a_d     = op1;
          b_d     = op2;
          idx_d   = IDXW'(N - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!s_eq) begin
          result_d    = form_result(op_q, s_lt, 1'b0, a_q, b_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          result_d    = form_result(op_q, 1'b0, 1'b1, a_q, b_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= CMP_SLT;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
